// File: rtl/pxl_streamer.sv
`timescale 1ns/1ps
// pxl_streamer: single-frame image buffer that streams its pixels in raster order
// to the first CNN layer, one pixel per clock with a valid strobe and stall support.
module pxl_streamer #(
  parameter int unsigned PP     = 8,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic signed [PP:0]         wr_data,
  output logic                       wr_err,
  input  logic                       start,
  input  logic                       stall,
  output logic signed [PP:0]         pxl_out,
  output logic                       pxl_valid,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic [$clog2(IMG_W)-1:0]   col,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned RW   = $clog2(IMG_H);
  localparam int unsigned CW   = $clog2(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [PP:0] mem [NPIX];

  logic [ADDR_W-1:0]  rd_addr;
  logic               addr_vld;
  logic signed [PP:0] rd_data;
  logic               rd_vld;
  logic [RW-1:0]      nxt_row;
  logic [CW-1:0]      nxt_col;
  logic               last_addr;

  logic busy_d, done_d, wr_err_d, wr_ok_c, accept_c;

  assign last_addr = (rd_addr == ADDR_W'(NPIX - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if (!stall && last_addr) state_nxt = S_FLUSH;
      S_FLUSH:  if (!rd_vld) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control decodes; status flags are registered from the upcoming state
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    wr_err_d = 1'b0;
    wr_ok_c  = 1'b0;
    accept_c = 1'b0;
    busy_d   = (state_nxt == S_STREAM) || (state_nxt == S_FLUSH);
    done_d   = (state_nxt == S_DONE);
    accept_c = (state == S_IDLE) && start;
    wr_ok_c  = wr_en && (state == S_IDLE) && (32'(wr_addr) < NPIX);
    wr_err_d = wr_en && (state != S_IDLE);
  end

  // Frame RAM: writes only while idle, reads advance with the unstalled pipeline
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_addr] <= wr_data;
    if (!stall && addr_vld) rd_data <= mem[rd_addr];
  end

  // Address / read / output pipeline; a stall freezes every stage together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr   <= '0;
      addr_vld  <= 1'b0;
      rd_vld    <= 1'b0;
      nxt_row   <= '0;
      nxt_col   <= '0;
      pxl_out   <= '0;
      pxl_valid <= 1'b0;
      row       <= '0;
      col       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      wr_err    <= wr_err_d;
      pxl_valid <= 1'b0;
      if (accept_c) begin
        rd_addr  <= '0;
        addr_vld <= 1'b1;
        nxt_row  <= '0;
        nxt_col  <= '0;
      end else if (!stall) begin
        if (addr_vld) begin
          if (last_addr) addr_vld <= 1'b0;
          else           rd_addr  <= rd_addr + ADDR_W'(1);
        end
        rd_vld    <= addr_vld;
        pxl_valid <= rd_vld;
        if (rd_vld) begin
          pxl_out <= rd_data;
          row     <= nxt_row;
          col     <= nxt_col;
          if (nxt_col == CW'(IMG_W - 1)) begin
            nxt_col <= '0;
            nxt_row <= nxt_row + RW'(1);
          end else begin
            nxt_col <= nxt_col + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pxl_streamer.sv
`timescale 1ns/1ps
// Bench for pxl_streamer: startup/latency vector table, then whole frames checked
// beat by beat against an array model of the frame RAM and raster indexing.
module tb_pxl_streamer;

  localparam int unsigned PP     = 8;
  localparam int unsigned PW     = PP + 1;
  localparam int unsigned IMG_W  = 32;
  localparam int unsigned IMG_H  = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned RW     = $clog2(IMG_H);
  localparam int unsigned CW     = $clog2(IMG_W);
  localparam int          CYC_LIMIT = 4 * NPIX + 100;
  localparam int          NVEC   = 9;

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic signed [PP:0] wr_data;
  logic               wr_err;
  logic               start;
  logic               stall;
  logic signed [PP:0] pxl_out;
  logic               pxl_valid;
  logic [RW-1:0]      row;
  logic [CW-1:0]      col;
  logic               busy;
  logic               done;

  pxl_streamer #(.PP(PP), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .start(start), .stall(stall), .pxl_out(pxl_out),
    .pxl_valid(pxl_valid), .row(row), .col(col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int we; int wa; int wd; int st; int sl;
    int e_busy; int e_err; int e_vld; int e_pix; int e_row; int e_col; int e_done;
  } vec_t;

  vec_t               vecs [NVEC];
  logic signed [PP:0] ref_mem [NPIX];
  int                 stall_plan [NPIX];
  int                 n_pass = 0;
  int                 n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pxl_out"},   int'(pxl_out),   0);
    check({tag, "_pxl_valid"}, int'(pxl_valid), 0);
    check({tag, "_row"},       int'(row),       0);
    check({tag, "_col"},       int'(col),       0);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_done"},      int'(done),      0);
    check({tag, "_wr_err"},    int'(wr_err),    0);
  endtask

  task automatic clear_plan();
    foreach (stall_plan[i]) stall_plan[i] = 0;
  endtask

  // Start accepted at T0; nothing valid after T0 or T0+1
  task automatic start_frame(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_at_T0"},  int'(busy), 1);
    check({tag, "_vld_at_T0"},   int'(pxl_valid), 0);
    tick();
    check({tag, "_vld_at_T0+1"}, int'(pxl_valid), 0);
  endtask

  // Collect beats from first_beat to the end of the frame and check the done pulse
  task automatic stream(input string tag, input int first_beat, input bit rand_stall,
                        input int illegal_at, input int abort_at, input bit bb_next,
                        output int nstall);
    int beat, cyc, bad, gaps, dones, errbad, err_ones, busybad, first_bad, stall_left, nz;
    bit st_now, ill_armed, exp_err;
    beat = first_beat; cyc = 0; bad = 0; gaps = 0; dones = 0; errbad = 0; err_ones = 0;
    busybad = 0; first_bad = -1; stall_left = 0; nstall = 0; ill_armed = 1'b0;
    while (beat < int'(NPIX) && cyc < CYC_LIMIT) begin
      st_now = (stall_left > 0) || (rand_stall && $urandom_range(3) == 0);
      if (stall_left > 0) stall_left--;
      stall = st_now;
      tick();
      cyc++;
      exp_err = ill_armed;
      if (ill_armed) begin
        ill_armed = 1'b0; wr_en = 1'b0; start = 1'b0;
      end
      if (wr_err !== exp_err) errbad++;
      if (wr_err === 1'b1) err_ones++;
      if (done !== 1'b0) dones++;
      if (busy !== 1'b1) busybad++;
      if (st_now) begin
        nstall++;
        if (pxl_valid !== 1'b0) bad++;
        else if (beat > 0 && (pxl_out !== ref_mem[beat-1] ||
                 row !== RW'((beat-1) / IMG_W) || col !== CW'((beat-1) % IMG_W))) bad++;
      end else if (pxl_valid !== 1'b1) begin
        gaps++;
      end else begin
        if (pxl_out !== ref_mem[beat] || row !== RW'(beat / IMG_W) || col !== CW'(beat % IMG_W)) begin
          bad++;
          if (first_bad < 0) first_bad = beat;
        end
        stall_left = stall_plan[beat];
        if (beat == illegal_at) begin
          start = 1'b1; wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_data = PW'(170); ill_armed = 1'b1;
        end
        beat++;
        if (beat - 1 == abort_at) break;
      end
    end
    stall = 1'b0;
    check($sformatf("%s_data_errs(first@%0d)", tag, first_bad), bad, 0);
    check({tag, "_gaps"},       gaps, 0);
    check({tag, "_early_done"}, dones, 0);
    check({tag, "_wr_err"},     errbad, 0);
    check({tag, "_wr_err_cnt"}, err_ones, (illegal_at >= 0) ? 1 : 0);
    check({tag, "_busy_drop"},  busybad, 0);
    if (abort_at >= 0) begin
      check({tag, "_beats_before_abort"}, beat, abort_at + 1);
      reset = 1'b0;
      #1;
      check_zero({tag, "_async"});
      nz = 0;
      repeat (3) begin
        tick();
        if (pxl_valid || busy || done || wr_err || pxl_out != 0) nz++;
      end
      reset = 1'b1;
      repeat (5) begin
        tick();
        if (pxl_valid || busy || done) nz++;
      end
      check({tag, "_quiet_after_reset"}, nz, 0);
      return;
    end
    check({tag, "_beats"}, beat, int'(NPIX));
    tick();
    check({tag, "_done"},      int'(done), 1);
    check({tag, "_done_busy"}, int'(busy), 0);
    check({tag, "_done_vld"},  int'(pxl_valid), 0);
    check({tag, "_last_row"},  int'(row), int'(IMG_H) - 1);
    check({tag, "_last_col"},  int'(col), int'(IMG_W) - 1);
    if (bb_next) start = 1'b1;
    tick();
    check({tag, "_done_once"},     int'(done), 0);
    check({tag, "_start_in_done"}, int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz, ns;
    int a;
    logic signed [PP:0] d;

    vecs[0] = '{1, 3, 77, 1, 0,  1, 0, 0,    0, 0, 0, 0};
    vecs[1] = '{1, 4, 99, 0, 0,  1, 1, 0,    0, 0, 0, 0};
    vecs[2] = '{0, 0, 0,  0, 0,  1, 0, 1, -128, 0, 0, 0};
    vecs[3] = '{0, 0, 0,  0, 1,  1, 0, 0, -128, 0, 0, 0};
    vecs[4] = '{0, 0, 0,  0, 1,  1, 0, 0, -128, 0, 0, 0};
    vecs[5] = '{0, 0, 0,  0, 0,  1, 0, 1, -127, 0, 1, 0};
    vecs[6] = '{0, 0, 0,  1, 0,  1, 0, 1, -126, 0, 2, 0};
    vecs[7] = '{0, 0, 0,  0, 0,  1, 0, 1,   77, 0, 3, 0};
    vecs[8] = '{0, 0, 0,  0, 0,  1, 0, 1, -124, 0, 4, 0};
    clear_plan();

    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; stall = 1'b0;
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'($urandom); start = 1'($urandom); stall = 1'($urandom);
      wr_addr = ADDR_W'($urandom); wr_data = PW'($urandom);
      tick();
      if (pxl_valid || busy || done || wr_err || pxl_out != 0 || row != 0 || col != 0) nz++;
    end
    check("reset_hold_nonzero_cycles", nz, 0);
    check_zero("reset");

    wr_en = 1'b0; start = 1'b0; stall = 1'b0;
    reset = 1'b1;
    nz = 0;
    repeat (100) begin
      tick();
      if (pxl_valid || busy || done || wr_err) nz++;
    end
    check("idle_no_activity", nz, 0);

    nz = 0;
    for (int i = 0; i < int'(NPIX); i++) begin
      d = PW'((i % 256) - 128);
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = d; ref_mem[i] = d;
      tick();
      if (wr_err) nz++;
    end
    wr_en = 1'b0;
    check("load_wr_err", nz, 0);

    for (int v = 0; v < NVEC; v++) begin
      wr_en = 1'(vecs[v].we); wr_addr = ADDR_W'(vecs[v].wa); wr_data = PW'(vecs[v].wd);
      start = 1'(vecs[v].st); stall = 1'(vecs[v].sl);
      tick();
      check($sformatf("tbl%0d_busy", v),   int'(busy),      vecs[v].e_busy);
      check($sformatf("tbl%0d_wr_err", v), int'(wr_err),    vecs[v].e_err);
      check($sformatf("tbl%0d_vld", v),    int'(pxl_valid), vecs[v].e_vld);
      check($sformatf("tbl%0d_pix", v),    int'(pxl_out),   vecs[v].e_pix);
      check($sformatf("tbl%0d_row", v),    int'(row),       vecs[v].e_row);
      check($sformatf("tbl%0d_col", v),    int'(col),       vecs[v].e_col);
      check($sformatf("tbl%0d_done", v),   int'(done),      vecs[v].e_done);
    end
    wr_en = 1'b0; start = 1'b0; stall = 1'b0;
    ref_mem[3] = PW'(77);
    stream("tbl_frame", 5, 1'b0, -1, -1, 1'b0, ns);

    d = PW'(-125);
    wr_en = 1'b1; wr_addr = ADDR_W'(3); wr_data = d;
    tick();
    wr_en = 1'b0;
    ref_mem[3] = d;
    check("restore_wr_err", int'(wr_err), 0);

    start_frame("basic");
    stream("basic", 0, 1'b0, -1, -1, 1'b1, ns);
    check("basic_stall_cycles", ns, 0);

    stall_plan[31] = 1;
    stall_plan[40] = 3;
    start_frame("b2b_stall");
    stream("b2b_stall", 0, 1'b0, -1, -1, 1'b0, ns);
    check("b2b_stall_cycles", ns, 4);
    clear_plan();

    start_frame("illegal");
    stream("illegal", 0, 1'b0, 100, -1, 1'b0, ns);

    start_frame("abort");
    stream("abort", 0, 1'b0, -1, 500, 1'b0, ns);

    start_frame("after_reset");
    stream("after_reset", 0, 1'b0, -1, -1, 1'b0, ns);

    nz = 0;
    for (int k = 0; k < 300; k++) begin
      a = int'($urandom_range(NPIX - 1));
      d = PW'($urandom);
      wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d; ref_mem[a] = d;
      tick();
      if (wr_err) nz++;
    end
    wr_en = 1'b0;
    check("rand_load_wr_err", nz, 0);
    start_frame("random");
    stream("random", 0, 1'b1, -1, -1, 1'b0, ns);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
